// File: rtl/ex_iter_pkg.sv
// Shared types for the iterative multiply/divide execute stage: op codes,
// FSM states, datapath command encoding and the latency helper.
package ex_iter_pkg;

    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_MULT   = 3'd1,
        OP_MULTU  = 3'd2,
        OP_DIV    = 3'd3,
        OP_DIVU   = 3'd4,
        OP_MADD   = 3'd5,
        OP_MSUB   = 3'd6,
        OP_MTHILO = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        DP_HOLD     = 3'd0,
        DP_LOAD     = 3'd1,
        DP_MUL_STEP = 3'd2,
        DP_DIV_STEP = 3'd3,
        DP_FIX      = 3'd4
    } dp_cmd_e;

    typedef enum logic [1:0] {
        ACC_NONE = 2'd0,
        ACC_ADD  = 2'd1,
        ACC_SUB  = 2'd2
    } acc_mode_e;

    // Accept edge to OutValid for iterated ops: DATA_W steps plus FIX plus DONE.
    function automatic int unsigned iter_latency(input int unsigned data_w);
        return data_w + 32'd2;
    endfunction

    function automatic logic is_signed_op(input op_e op);
        case (op)
            OP_MULT, OP_DIV, OP_MADD, OP_MSUB: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ex_iter_datapath.sv
// Hi/Lo shift registers, operand and accumulator registers, iteration counter.
// Restoring divide step is present only when EX_ITER_DIV_EN is defined.
module ex_iter_datapath
    import ex_iter_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  dp_cmd_e               cmd,
    input  logic [DATA_W-1:0]     load_hi,
    input  logic [DATA_W-1:0]     load_lo,
    input  logic [DATA_W-1:0]     load_opnd,
    input  logic [2*DATA_W-1:0]   load_acc,
    input  logic                  neg_full,
    input  acc_mode_e             acc_mode,
    input  logic                  neg_hi,
    input  logic                  neg_lo,
    output logic [DATA_W-1:0]     hi,
    output logic [DATA_W-1:0]     lo,
    output logic                  last
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W:0]     mul_sum_s;
    logic [2*DATA_W-1:0] prod_s, acc_res_s;
    logic [DATA_W-1:0]   fix_hi_s, fix_lo_s;
`ifdef EX_ITER_DIV_EN
    logic [DATA_W:0]     div_rem_s, div_diff_s;
`endif

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign last = (cnt_q == CNT_W'(DATA_W - 1));

    // Step arithmetic and next-state selection for the datapath registers.
    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        opnd_d = opnd_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;

        // Multiply: add multiplicand when the next multiplier bit (lo[0]) is set.
        mul_sum_s = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(DATA_W+1){1'b0}});

        prod_s = neg_full ? -{hi_q, lo_q} : {hi_q, lo_q};
        case (acc_mode)
            ACC_ADD: acc_res_s = acc_q + prod_s;
            ACC_SUB: acc_res_s = acc_q - prod_s;
            default: acc_res_s = prod_s;
        endcase
        fix_hi_s = neg_hi ? -acc_res_s[2*DATA_W-1:DATA_W] : acc_res_s[2*DATA_W-1:DATA_W];
        fix_lo_s = neg_lo ? -acc_res_s[DATA_W-1:0]        : acc_res_s[DATA_W-1:0];

`ifdef EX_ITER_DIV_EN
        // Remainder lives in hi, dividend shifts out of lo while quotient shifts in.
        div_rem_s  = {hi_q, lo_q[DATA_W-1]};
        div_diff_s = div_rem_s - {1'b0, opnd_q};
`endif

        case (cmd)
            DP_LOAD: begin
                hi_d   = load_hi;
                lo_d   = load_lo;
                opnd_d = load_opnd;
                acc_d  = load_acc;
                cnt_d  = {CNT_W{1'b0}};
            end
            DP_MUL_STEP: begin
                hi_d  = mul_sum_s[DATA_W:1];
                lo_d  = {mul_sum_s[0], lo_q[DATA_W-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
            end
`ifdef EX_ITER_DIV_EN
            DP_DIV_STEP: begin
                hi_d  = div_diff_s[DATA_W] ? div_rem_s[DATA_W-1:0] : div_diff_s[DATA_W-1:0];
                lo_d  = {lo_q[DATA_W-2:0], ~div_diff_s[DATA_W]};
                cnt_d = cnt_q + CNT_W'(1);
            end
`endif
            DP_FIX: begin
                hi_d = fix_hi_s;
                lo_d = fix_lo_s;
            end
            default: begin
            end
        endcase
    end

    // Datapath register bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q   <= {DATA_W{1'b0}};
            lo_q   <= {DATA_W{1'b0}};
            opnd_q <= {DATA_W{1'b0}};
            acc_q  <= {(2*DATA_W){1'b0}};
            cnt_q  <= {CNT_W{1'b0}};
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            opnd_q <= opnd_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/ex_stage_iter.sv
// Iterative multiply / divide / multiply-accumulate execute stage with
// valid/ready handshakes. Define EX_ITER_DIV_EN to include the divider.
module ex_stage_iter
    import ex_iter_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  InValid,
    output logic                  InReady,
    input  logic [2:0]            Op,
    input  logic [DATA_W-1:0]     OpA,
    input  logic [DATA_W-1:0]     OpB,
    input  logic [DATA_W-1:0]     HiIn,
    input  logic [DATA_W-1:0]     LoIn,
    input  logic [RADDR_W-1:0]    RdIn,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic [2*DATA_W-1:0]   oHiLo,
    output logic                  oHiLoWrite,
    output logic [RADDR_W-1:0]    oRd,
    output logic                  oBusy
);

    state_e              state_q, state_d;
    logic [RADDR_W-1:0]  rd_q, rd_d;
    logic                wr_q, wr_d;
    logic                neg_full_q, neg_full_d;
    acc_mode_e           acc_mode_q, acc_mode_d;
    logic                neg_hi_q, neg_hi_d;
    logic                neg_lo_q, neg_lo_d;

    op_e                 op_s;
    logic                a_neg_s, b_neg_s;
    logic [DATA_W-1:0]   a_mag_s, b_mag_s;
    dp_cmd_e             dp_cmd_s;
    logic [DATA_W-1:0]   load_hi_s, load_lo_s, load_opnd_s;
    logic [DATA_W-1:0]   dp_hi_s, dp_lo_s;
    logic                dp_last_s;

    assign InReady    = (state_q == S_IDLE);
    assign oBusy      = (state_q != S_IDLE);
    assign OutValid   = (state_q == S_DONE);
    assign oHiLoWrite = wr_q;
    assign oRd        = rd_q;
    assign oHiLo      = {dp_hi_s, dp_lo_s};

    // Signed ops iterate on magnitudes; the sign is restored in FIX.
    always_comb begin
        op_s    = op_e'(Op);
        a_neg_s = is_signed_op(op_s) & OpA[DATA_W-1];
        b_neg_s = is_signed_op(op_s) & OpB[DATA_W-1];
        a_mag_s = a_neg_s ? -OpA : OpA;
        b_mag_s = b_neg_s ? -OpB : OpB;
    end

    // Next-state, datapath command and per-op control flags.
    always_comb begin
        state_d     = state_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        neg_full_d  = neg_full_q;
        acc_mode_d  = acc_mode_q;
        neg_hi_d    = neg_hi_q;
        neg_lo_d    = neg_lo_q;
        dp_cmd_s    = DP_HOLD;
        load_hi_s   = {DATA_W{1'b0}};
        load_lo_s   = {DATA_W{1'b0}};
        load_opnd_s = {DATA_W{1'b0}};

        case (state_q)
            S_IDLE: begin
                if (InValid) begin
                    rd_d       = RdIn;
                    wr_d       = 1'b0;
                    neg_full_d = 1'b0;
                    acc_mode_d = ACC_NONE;
                    neg_hi_d   = 1'b0;
                    neg_lo_d   = 1'b0;
                    dp_cmd_s   = DP_LOAD;
                    case (op_s)
                        OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
                            load_lo_s   = b_mag_s;
                            load_opnd_s = a_mag_s;
                            neg_full_d  = a_neg_s ^ b_neg_s;
                            acc_mode_d  = (op_s == OP_MADD) ? ACC_ADD :
                                          (op_s == OP_MSUB) ? ACC_SUB : ACC_NONE;
                            state_d     = S_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
`ifdef EX_ITER_DIV_EN
                            if (OpB == {DATA_W{1'b0}}) begin
                                load_hi_s = OpA;
                                load_lo_s = {DATA_W{1'b1}};
                                wr_d      = 1'b1;
                                state_d   = S_DONE;
                            end else begin
                                load_lo_s   = a_mag_s;
                                load_opnd_s = b_mag_s;
                                neg_lo_d    = a_neg_s ^ b_neg_s;
                                neg_hi_d    = a_neg_s;
                                state_d     = S_DIV;
                            end
`else
                            state_d = S_DONE;
`endif
                        end
                        OP_MTHILO: begin
                            load_hi_s = OpA;
                            load_lo_s = OpB;
                            wr_d      = 1'b1;
                            state_d   = S_DONE;
                        end
                        default: begin
                            state_d = S_DONE;
                        end
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                dp_cmd_s = DP_MUL_STEP;
                if (dp_last_s) begin
                    state_d = S_FIX;
                end else begin
                    state_d = S_MUL;
                end
            end
            S_DIV: begin
`ifdef EX_ITER_DIV_EN
                dp_cmd_s = DP_DIV_STEP;
                if (dp_last_s) begin
                    state_d = S_FIX;
                end else begin
                    state_d = S_DIV;
                end
`else
                state_d = S_IDLE;
`endif
            end
            S_FIX: begin
                dp_cmd_s = DP_FIX;
                wr_d     = 1'b1;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (OutReady) begin
                    wr_d    = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state and per-op flags.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            rd_q       <= {RADDR_W{1'b0}};
            wr_q       <= 1'b0;
            neg_full_q <= 1'b0;
            acc_mode_q <= ACC_NONE;
            neg_hi_q   <= 1'b0;
            neg_lo_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            neg_full_q <= neg_full_d;
            acc_mode_q <= acc_mode_d;
            neg_hi_q   <= neg_hi_d;
            neg_lo_q   <= neg_lo_d;
        end
    end

    ex_iter_datapath #(
        .DATA_W (DATA_W)
    ) u_datapath (
        .clk       (Clk),
        .rst       (Reset),
        .cmd       (dp_cmd_s),
        .load_hi   (load_hi_s),
        .load_lo   (load_lo_s),
        .load_opnd (load_opnd_s),
        .load_acc  ({HiIn, LoIn}),
        .neg_full  (neg_full_q),
        .acc_mode  (acc_mode_q),
        .neg_hi    (neg_hi_q),
        .neg_lo    (neg_lo_q),
        .hi        (dp_hi_s),
        .lo        (dp_lo_s),
        .last      (dp_last_s)
    );

endmodule

// File: tb/tb_ex_stage_iter.sv
// Self-checking bench for ex_stage_iter (DATA_W=32): directed table with
// hand-computed results plus randomized ops against an arithmetic model.
module tb_ex_stage_iter;

    localparam int DATA_W  = 32;
    localparam int RADDR_W = 5;

    logic               Clk = 1'b0;
    logic               Reset;
    logic               InValid;
    logic               InReady;
    logic [2:0]         Op;
    logic [31:0]        OpA, OpB, HiIn, LoIn;
    logic [4:0]         RdIn;
    logic               OutValid;
    logic               OutReady;
    logic [63:0]        oHiLo;
    logic               oHiLoWrite;
    logic [4:0]         oRd;
    logic               oBusy;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    ex_stage_iter #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .InValid    (InValid),
        .InReady    (InReady),
        .Op         (Op),
        .OpA        (OpA),
        .OpB        (OpB),
        .HiIn       (HiIn),
        .LoIn       (LoIn),
        .RdIn       (RdIn),
        .OutValid   (OutValid),
        .OutReady   (OutReady),
        .oHiLo      (oHiLo),
        .oHiLoWrite (oHiLoWrite),
        .oRd        (oRd),
        .oBusy      (oBusy)
    );

    // Reference: plain integer arithmetic on the op semantics.
    function automatic void ref_model(input logic [2:0] op, input logic [31:0] a, b, hi, lo,
                                      output logic [63:0] e, output logic ew, output int el);
        longint sa, sb, sq, sr;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        e  = 64'd0;
        ew = 1'b1;
        el = 34;
        case (op)
            3'd1: e = sa * sb;
            3'd2: e = ua * ub;
            3'd5: e = {hi, lo} + sa * sb;
            3'd6: e = {hi, lo} - sa * sb;
`ifdef EX_ITER_DIV_EN
            3'd3, 3'd4: begin
                if (b == 32'd0) begin
                    e  = {a, 32'hFFFF_FFFF};
                    el = 1;
                end else if (op == 3'd3) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    e  = {sr[31:0], sq[31:0]};
                end else begin
                    sq = longint'(ua / ub);
                    sr = longint'(ua % ub);
                    e  = {sr[31:0], sq[31:0]};
                end
            end
`else
            3'd3, 3'd4: begin
                ew = 1'b0;
                el = 1;
            end
`endif
            3'd7: begin
                e  = {a, b};
                el = 1;
            end
            default: begin
                ew = 1'b0;
                el = 1;
            end
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Present one request, then scramble inputs and wait (bounded) for OutValid.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, b, hi, lo, input logic [4:0] rd,
                         output int lat, output logic busy_ok);
        @(negedge Clk);
        Op = op; OpA = a; OpB = b; HiIn = hi; LoIn = lo; RdIn = rd; InValid = 1'b1;
        @(posedge Clk);
        #1;
        InValid = 1'b0;
        Op = 3'($urandom); OpA = $urandom; OpB = $urandom; HiIn = $urandom; LoIn = $urandom; RdIn = 5'($urandom);
        lat = 1;
        busy_ok = 1'b1;
        while (!OutValid && lat < 100) begin
            if (!oBusy || InReady) busy_ok = 1'b0;
            @(posedge Clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; InValid = 1'b0; OutReady = 1'b1;
        Op = 3'd0; OpA = 32'd0; OpB = 32'd0; HiIn = 32'd0; LoIn = 32'd0; RdIn = 5'd0;
        repeat (3) @(posedge Clk);
        #1;
        checks++;
        if ({OutValid, oHiLoWrite, oBusy} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got %b want 000", {OutValid, oHiLoWrite, oBusy});
        end
        checks++;
        if (oHiLo !== 64'd0 || oRd !== 5'd0) begin
            errors++; $display("FAIL reset_data got %h/%h want 0/0", oHiLo, oRd);
        end
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        checks++;
        if (InReady !== 1'b1) begin
            errors++; $display("FAIL reset_inready got %b want 1", InReady);
        end
    endtask

    task automatic test_directed();
        logic [2:0]  d_op [13] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd3, 3'd6, 3'd1, 3'd0, 3'd3, 3'd7, 3'd1, 3'd4, 3'd6};
        logic [31:0] d_a  [13] = '{32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h0000_1234, 32'd1, 32'h8000_0000, 32'd3,
                                   32'hFFFF_FFFF, 32'h0000_DEAD, 32'd100, 32'hCAFE_0000, 32'h8000_0000,
                                   32'hFFFF_FFFF, 32'd1};
        logic [31:0] d_b  [13] = '{32'd2, 32'd2, 32'd0, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'hFFFF_FFFF,
                                   32'h0000_BEEF, 32'd0, 32'h0000_F00D, 32'h8000_0000, 32'h0000_0010, 32'd1};
        logic [31:0] d_hi [13] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
                                   32'd0, 32'd0, 32'd0};
        logic [31:0] d_lo [13] = '{32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd5, 32'd0, 32'd0, 32'd0,
                                   32'd0, 32'd0, 32'd0, 32'd0};
`ifdef EX_ITER_DIV_EN
        logic [63:0] x_hl [13] = '{64'h0000_0001_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_1234_FFFF_FFFF,
                                   64'h0000_0001_0000_0000, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0011,
                                   64'h0000_0000_0000_0001, 64'd0, 64'h0000_0064_FFFF_FFFF,
                                   64'hCAFE_0000_0000_F00D, 64'h4000_0000_0000_0000, 64'h0000_000F_0FFF_FFFF,
                                   64'hFFFF_FFFF_FFFF_FFFF};
        logic        x_wr [13] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        int          x_lt [13] = '{34, 34, 1, 34, 34, 34, 34, 1, 1, 1, 34, 34, 34};
`else
        logic [63:0] x_hl [13] = '{64'h0000_0001_FFFF_FFFE, 64'd0, 64'd0,
                                   64'h0000_0001_0000_0000, 64'd0, 64'h0000_0000_0000_0011,
                                   64'h0000_0000_0000_0001, 64'd0, 64'd0,
                                   64'hCAFE_0000_0000_F00D, 64'h4000_0000_0000_0000, 64'd0,
                                   64'hFFFF_FFFF_FFFF_FFFF};
        logic        x_wr [13] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        int          x_lt [13] = '{34, 1, 1, 34, 1, 34, 34, 1, 1, 1, 34, 1, 34};
`endif
        int   lat;
        logic busy_ok;
        OutReady = 1'b1;
        for (int i = 0; i < 13; i++) begin
            issue(d_op[i], d_a[i], d_b[i], d_hi[i], d_lo[i], 5'(i + 3), lat, busy_ok);
            checks++;
            if (lat !== x_lt[i]) begin
                errors++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, x_lt[i]);
            end
            checks++;
            if (oHiLo !== x_hl[i] || oHiLoWrite !== x_wr[i]) begin
                errors++; $display("FAIL dir%0d_result got %h/%b want %h/%b", i, oHiLo, oHiLoWrite, x_hl[i], x_wr[i]);
            end
            checks++;
            if (oRd !== 5'(i + 3) || busy_ok !== 1'b1) begin
                errors++; $display("FAIL dir%0d_rd_busy got %0d/%b want %0d/1", i, oRd, busy_ok, i + 3);
            end
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b, hi, lo;
        logic [4:0]  rd;
        logic [63:0] e;
        logic        ew, busy_ok;
        int          el, lat;
        OutReady = 1'b1;
        for (int n = 0; n < 40; n++) begin
            op = 3'($urandom_range(0, 7));
            a = pick_operand(); b = pick_operand(); hi = $urandom; lo = $urandom; rd = 5'($urandom);
            ref_model(op, a, b, hi, lo, e, ew, el);
            issue(op, a, b, hi, lo, rd, lat, busy_ok);
            checks++;
            if (lat !== el || oHiLo !== e || oHiLoWrite !== ew || oRd !== rd || busy_ok !== 1'b1) begin
                errors++;
                $display("FAIL rand%0d op%0d a=%h b=%h got lat %0d hl %h w %b rd %0d busy %b want lat %0d hl %h w %b rd %0d",
                         n, op, a, b, lat, oHiLo, oHiLoWrite, oRd, busy_ok, el, e, ew, rd);
            end
            @(posedge Clk);
            #1;
            checks++;
            if (OutValid !== 1'b0 || InReady !== 1'b1) begin
                errors++; $display("FAIL rand%0d_retire got ov %b ir %b want 0 1", n, OutValid, InReady);
            end
        end
    endtask

    task automatic test_reset_mid();
        int   lat;
        logic busy_ok;
        OutReady = 1'b1;
        @(negedge Clk);
        Op = 3'd1; OpA = 32'h1234_5678; OpB = 32'hFFFF_0001; RdIn = 5'd17; InValid = 1'b1;
        @(posedge Clk);
        #1;
        InValid = 1'b0;
        repeat (9) @(posedge Clk);
        #1;
        Reset = 1'b1;
        #2;
        checks++;
        if ({OutValid, oHiLoWrite, oBusy} !== 3'b000 || oHiLo !== 64'd0 || oRd !== 5'd0) begin
            errors++; $display("FAIL midreset_outputs got %b %h %0d want 000 0 0", {OutValid, oHiLoWrite, oBusy}, oHiLo, oRd);
        end
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        checks++;
        if (InReady !== 1'b1) begin
            errors++; $display("FAIL midreset_inready got %b want 1", InReady);
        end
        issue(3'd7, 32'd5, 32'd6, 32'd0, 32'd0, 5'd9, lat, busy_ok);
        checks++;
        if (lat !== 1 || oHiLo !== {32'd5, 32'd6} || oHiLoWrite !== 1'b1) begin
            errors++; $display("FAIL midreset_mthilo got lat %0d hl %h w %b want 1 %h 1", lat, oHiLo, oHiLoWrite, {32'd5, 32'd6});
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic test_hold();
        int          lat;
        logic        busy_ok;
        logic [31:0] a, b;
        a = $urandom; b = $urandom;
        OutReady = 1'b0;
        issue(3'd7, a, b, 32'd0, 32'd0, 5'd21, lat, busy_ok);
        checks++;
        if (lat !== 1 || oHiLo !== {a, b}) begin
            errors++; $display("FAIL hold_first got lat %0d hl %h want 1 %h", lat, oHiLo, {a, b});
        end
        @(negedge Clk);
        InValid = 1'b1; Op = 3'd2; OpA = $urandom; OpB = $urandom;
        for (int c = 0; c < 20; c++) begin
            @(posedge Clk);
            #1;
            checks++;
            if (OutValid !== 1'b1 || oHiLo !== {a, b} || InReady !== 1'b0 || oRd !== 5'd21) begin
                errors++; $display("FAIL hold_cycle%0d got ov %b hl %h ir %b rd %0d want 1 %h 0 21", c, OutValid, oHiLo, InReady, oRd, {a, b});
            end
        end
        @(negedge Clk);
        InValid = 1'b0;
        OutReady = 1'b1;
        @(posedge Clk);
        #1;
        checks++;
        if (OutValid !== 1'b0 || InReady !== 1'b1 || oBusy !== 1'b0) begin
            errors++; $display("FAIL hold_release got ov %b ir %b busy %b want 0 1 0", OutValid, InReady, oBusy);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_reset_mid();
        test_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
